// File: rtl/falling_edge_generator.sv
// falling_edge_generator: on request, hold low for delay_i+1 cycles, high for max(high_i,1), then fall with a one-cycle fall_o pulse.
// Optional abort_i input enabled by defining FALL_EDGE_GEN_ABORT_EN.
module falling_edge_generator #(
  parameter int DELAY_W = 8,
  parameter int HIGH_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_i,
  input  logic [DELAY_W-1:0] delay_i,
  input  logic [HIGH_W-1:0]  high_i,
`ifdef FALL_EDGE_GEN_ABORT_EN
  input  logic               abort_i,
`endif
  output logic               ready_o,
  output logic               x_o,
  output logic               fall_o
);
  typedef enum logic [1:0] {IDLE, DELAY, HIGH} state_t;
  state_t state, state_n;
  logic [DELAY_W-1:0] dcnt, dcnt_n;
  logic [HIGH_W-1:0] hcnt, hcnt_n;
  logic x_n, fall_n, abort;
`ifdef FALL_EDGE_GEN_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif
  assign ready_o = state == IDLE;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state  <= IDLE;
      dcnt   <= '0;
      hcnt   <= '0;
      x_o    <= 1'b0;
      fall_o <= 1'b0;
    end else begin
      state  <= state_n;
      dcnt   <= dcnt_n;
      hcnt   <= hcnt_n;
      x_o    <= x_n;
      fall_o <= fall_n;
    end
  // A high time of zero is stretched to one so every accepted request yields a real pulse.
  always_comb begin
    state_n = state;
    dcnt_n  = dcnt;
    hcnt_n  = hcnt;
    x_n     = x_o;
    fall_n  = 1'b0;
    case (state)
      IDLE:
        if (req_i) begin
          state_n = DELAY;
          dcnt_n  = delay_i;
          hcnt_n  = high_i == '0 ? HIGH_W'(1) : high_i;
        end
      DELAY:
        if (abort) state_n = IDLE;
        else if (dcnt == '0) begin
          state_n = HIGH;
          x_n     = 1'b1;
        end else dcnt_n = dcnt - 1'b1;
      HIGH:
        if (abort || hcnt == HIGH_W'(1)) begin
          state_n = IDLE;
          x_n     = 1'b0;
          fall_n  = 1'b1;
        end else hcnt_n = hcnt - 1'b1;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_falling_edge_generator.sv
// tb_falling_edge_generator: scoreboard bench; expected {x_o,fall_o,ready_o} per cycle is queued at stimulus time.
module tb_falling_edge_generator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_i = 1'b0;
  logic [7:0] delay_i = '0;
  logic [7:0] high_i = '0;
  logic abort_i = 1'b0;
  logic ready_o, x_o, fall_o;
  logic [2:0] q[$];
  int n_checks = 0;
  int n_fail = 0;
  string tag;

  falling_edge_generator #(.DELAY_W(8), .HIGH_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .req_i(req_i),
    .delay_i(delay_i),
    .high_i(high_i),
`ifdef FALL_EDGE_GEN_ABORT_EN
    .abort_i(abort_i),
`endif
    .ready_o(ready_o),
    .x_o(x_o),
    .fall_o(fall_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string t, input logic [2:0] got, input logic [2:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got {x,fall,ready}=%b expected %b at %0t", t, got, exp, $time);
    end
  endtask

  task automatic push_n(input logic [2:0] v, input int n);
    repeat (n) q.push_back(v);
  endtask

  task automatic step();
    logic [2:0] e;
    @(posedge clk);
    #1;
    if (q.size() == 0) check({tag, "_underflow"}, {x_o, fall_o, ready_o}, 3'bxxx);
    else begin
      e = q.pop_front();
      check(tag, {x_o, fall_o, ready_o}, e);
    end
  endtask

  task automatic idle(input int n);
    push_n(3'b001, n);
    repeat (n) step();
  endtask

  task automatic pulse(input int d, input int h, input bit noise);
    int he;
    he = h == 0 ? 1 : h;
    req_i = 1'b1;
    delay_i = 8'(d);
    high_i = 8'(h);
    push_n(3'b000, d + 1);
    push_n(3'b100, he);
    push_n(3'b011, 1);
    step();
    req_i = 1'b0;
    repeat (d + he) begin
      if (noise) begin
        req_i = 1'($urandom);
        delay_i = 8'($urandom);
        high_i = 8'($urandom);
      end
      step();
    end
    req_i = 1'b0;
    step();
  endtask

  initial begin
    tag = "reset";
    #2 rst = 1'b0;
    req_i = 1'b1;
    delay_i = 8'd5;
    high_i = 8'd5;
    idle(4);
    @(negedge clk);
    req_i = 1'b0;
    rst = 1'b1;
    tag = "post_reset_idle";
    idle(3);
    tag = "d0_h4";
    pulse(0, 4, 0);
    idle(1);
    tag = "d3_h2";
    pulse(3, 2, 0);
    idle(1);
    tag = "d3_h0";
    pulse(3, 0, 0);
    idle(1);
    tag = "busy_ignore";
    pulse(2, 5, 1);
    idle(2);
    tag = "back_to_back";
    req_i = 1'b1;
    delay_i = 8'd0;
    high_i = 8'd2;
    repeat (3) begin
      push_n(3'b000, 1);
      push_n(3'b100, 2);
      push_n(3'b011, 1);
      repeat (4) step();
    end
    req_i = 1'b0;
    idle(2);
    tag = "rst_mid_high";
    req_i = 1'b1;
    delay_i = 8'd0;
    high_i = 8'd10;
    push_n(3'b000, 1);
    push_n(3'b100, 3);
    repeat (4) step();
    req_i = 1'b0;
    rst = 1'b0;
    #1 check("rst_async", {x_o, fall_o, ready_o}, 3'b001);
    tag = "rst_hold";
    idle(2);
    #2 rst = 1'b1;
    tag = "rst_release";
    idle(2);
    tag = "after_reset";
    pulse(1, 3, 0);
    idle(1);
    tag = "max_delay";
    pulse(255, 1, 0);
    tag = "max_high";
    pulse(0, 255, 0);
    idle(1);
`ifdef FALL_EDGE_GEN_ABORT_EN
    tag = "abort_high";
    req_i = 1'b1;
    delay_i = 8'd0;
    high_i = 8'd8;
    push_n(3'b000, 1);
    push_n(3'b100, 2);
    push_n(3'b011, 1);
    step();
    req_i = 1'b0;
    repeat (2) step();
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    idle(2);
    tag = "abort_delay";
    req_i = 1'b1;
    delay_i = 8'd6;
    high_i = 8'd3;
    push_n(3'b000, 2);
    repeat (2) step();
    req_i = 1'b0;
    abort_i = 1'b1;
    push_n(3'b001, 1);
    step();
    abort_i = 1'b0;
    idle(8);
    tag = "abort_idle_req";
    abort_i = 1'b1;
    req_i = 1'b1;
    delay_i = 8'd0;
    high_i = 8'd1;
    push_n(3'b000, 1);
    push_n(3'b100, 1);
    push_n(3'b011, 1);
    step();
    abort_i = 1'b0;
    req_i = 1'b0;
    repeat (2) step();
    idle(1);
`endif
    if (q.size() != 0) check("queue_drained", 3'(q.size()), 3'b000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
